div_operand_prep: RTL
=====================

# div_operand_prep

Operand front-end for the pipelined sign-magnitude non-restoring fractional divider. It buffers incoming dividend/divisor pairs in a small FIFO and strips the signs. It issues the magnitudes to the divider at most one per cycle. It also carries quotient/remainder sign and exception flags down a delay line, so they arrive aligned with the divider's result.

## Interface
Parameters:
- WIDTH, 16, magnitude bits; operands are WIDTH+1 bits with the sign in bit WIDTH.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- SB_LAT, 4, sideband delay in cycles from div_issue to sb_valid; set at integration to the divider latency.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  FIFO can accept.
- in_dividend  in  WIDTH+1  sign-magnitude fraction.
- in_divisor  in  WIDTH+1  sign-magnitude fraction.
- div_en  in  1  divider may accept an issue this cycle.
- div_issue  out  1  one-cycle strobe: div_dividend/div_divisor are valid.
- div_dividend  out  WIDTH+1  dividend magnitude, bit WIDTH = 0.
- div_divisor  out  WIDTH+1  divisor magnitude, bit WIDTH = 0.
- sb_valid  out  1  sideband word valid, SB_LAT cycles after its issue.
- sb_qsign  out  1  quotient sign.
- sb_rsign  out  1  remainder sign.
- sb_ovf  out  1  quotient overflow (|dividend| ≥ |divisor|, divisor ≠ 0).
- sb_dz  out  1  divide by zero (divisor magnitude 0).
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Push happens when in_valid && in_ready. in_ready = (count != DEPTH) && rst_n. When the FIFO is full, no push is accepted, even if a pop occurs in the same cycle.
- Pop happens when count != 0 && div_en. It is evaluated at each edge on the registered FIFO state. There is no bypass: an entry pushed into an empty FIFO pops at the next edge at the earliest.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged. Pointers wrap modulo DEPTH.
- On pop, the registered outputs are loaded:
  - magA = dividend[WIDTH-1:0], magB = divisor[WIDTH-1:0].
  - dz = (magB == 0).
  - ovf = !dz && (magA ≥ magB), an unsigned WIDTH-bit compare.
  - If dz or ovf, drive div_dividend = 0 and div_divisor = 1 << (WIDTH-1). The slot is still issued so alignment is kept.
  - Otherwise drive div_dividend = {0, magA} and div_divisor = {0, magB}.
  - qsign = dividend[WIDTH] ^ divisor[WIDTH]. It is forced to 0 when magA == 0, dz or ovf.
  - rsign = dividend[WIDTH]. It is forced to 0 when magA == 0.
- Sideband is a shift register SB_LAT deep with stages {valid, qsign, rsign, ovf, dz}. A stage is loaded with valid = 1 on a pop and valid = 0 otherwise. The shift register advances every cycle regardless of div_en.
- div_dividend and div_divisor hold their last value when there is no issue. div_issue is 0 on cycles without a pop.

## Timing
- Reset (rst_n low) immediately forces:
  - count, pointers, div_issue, div_dividend, div_divisor to 0;
  - all sideband stages to 0, so sb_* = 0;
  - in_ready = 0.
- On rst_n release, in_ready = 1 in the same cycle.
- Reset mid-operation discards FIFO contents and in-flight sideband. No sb_valid appears for pre-reset issues.
- Latency, no backpressure, empty FIFO: push at edge k gives div_issue high for cycle k+1 (registered at edge k+1). The matching sb_valid is high for the single cycle starting at edge k+1+SB_LAT.
- Throughput is one issue per cycle while count != 0 and div_en = 1. With continuous in_valid and div_en, a steady state of one push and one pop per cycle holds count at 1.
- div_en low stalls pops only. Bubbles enter the sideband line with valid = 0.

## Test plan
- Issue and sign stripping:
  - Stimulus: in_dividend = 0x00800, in_divisor = 0x18000, div_en = 1.
  - Required: div_issue one cycle later with div_dividend = 0x00800, div_divisor = 0x08000.
  - Required: sb_valid SB_LAT cycles after that with qsign = 1, rsign = 0, ovf = 0, dz = 0.
- Overflow:
  - Stimulus: in_dividend = 0x0A0A0, in_divisor = 0x01A1A.
  - Required: div_dividend = 0x00000, div_divisor = 0x08000; sideband ovf = 1, qsign = 0, rsign = 0.
- Divide by zero and negative zero:
  - Stimulus: in_dividend = 0x10000, in_divisor = 0x10000.
  - Required: sideband dz = 1, ovf = 0, qsign = 0, rsign = 0.
- Backpressure and full:
  - Stimulus: div_en = 0, push 5 pairs.
  - Required: in_ready drops after the 4th push, with count = 4.
  - Required: raising div_en produces 4 consecutive div_issue pulses in push order, and count returns to 0.
  - Required: the sb_valid pattern matches the issue pattern delayed by SB_LAT.
- Wrap and simultaneity:
  - Stimulus: 20 back-to-back pairs with div_en toggling every 3 cycles.
  - Required: every pair issues exactly once, in order. count never exceeds 4. Pointers wrap without loss.
- Reset mid-operation:
  - Stimulus: assert rst_n low with count = 3 and 2 issues in flight.
  - Required: all outputs read 0 asynchronously. No sb_valid follows. The first post-reset push issues normally.

Source files
------------

// File: rtl/div_operand_prep.sv
// Operand front-end for the sign-magnitude fractional divider: FIFO buffering,
// sign stripping, exception detection and a sideband delay line aligned to the divider.
module div_operand_prep #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int SB_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH:0]           in_dividend,
    input  logic [WIDTH:0]           in_divisor,
    input  logic                     div_en,
    output logic                     div_issue,
    output logic [WIDTH:0]           div_dividend,
    output logic [WIDTH:0]           div_divisor,
    output logic                     sb_valid,
    output logic                     sb_qsign,
    output logic                     sb_rsign,
    output logic                     sb_ovf,
    output logic                     sb_dz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH:0] dd;
        logic [WIDTH:0] dv;
        logic           qsign;
        logic           rsign;
        logic           ovf;
        logic           dz;
    } prep_t;

    // Exceptional slots still issue, with a harmless 0 / 0.5 operand pair.
    function automatic prep_t prep_operands(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        prep_t          p;
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic           zero_a;
        mag_a   = a[WIDTH-1:0];
        mag_b   = b[WIDTH-1:0];
        zero_a  = (mag_a == '0);
        p.dz    = (mag_b == '0);
        p.ovf   = !p.dz && (mag_a >= mag_b);
        p.qsign = (a[WIDTH] ^ b[WIDTH]) && !zero_a && !p.dz && !p.ovf;
        p.rsign = a[WIDTH] && !zero_a;
        if (p.dz || p.ovf) begin
            p.dd = '0;
            p.dv = {2'b01, {(WIDTH-1){1'b0}}};
        end else begin
            p.dd = {1'b0, mag_a};
            p.dv = {1'b0, mag_b};
        end
        return p;
    endfunction

    logic [WIDTH:0]  dvd_mem [DEPTH];
    logic [WIDTH:0]  dvs_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    prep_t           rd_prep;

    logic [3:0]      flags_p0;
    logic [4:0]      sb_p1 [SB_LAT];

    assign in_ready = (count != CW'(DEPTH)) && rst_n;
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && div_en;

    always_comb begin
        rd_prep = prep_operands(dvd_mem[rd_ptr], dvs_mem[rd_ptr]);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dvd_mem[wr_ptr] <= in_dividend;
            dvs_mem[wr_ptr] <= in_divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // p0: issue stage toward the divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_issue    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            flags_p0     <= '0;
        end else begin
            div_issue <= pop;
            if (pop) begin
                div_dividend <= rd_prep.dd;
                div_divisor  <= rd_prep.dv;
                flags_p0     <= {rd_prep.qsign, rd_prep.rsign, rd_prep.ovf, rd_prep.dz};
            end else begin
                flags_p0     <= '0;
            end
        end
    end

    // p1: sideband delay line, advancing every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SB_LAT; i++) sb_p1[i] <= '0;
        end else begin
            sb_p1[0] <= {div_issue, flags_p0};
            for (int i = 1; i < SB_LAT; i++) sb_p1[i] <= sb_p1[i-1];
        end
    end

    assign sb_valid = sb_p1[SB_LAT-1][4];
    assign sb_qsign = sb_p1[SB_LAT-1][3];
    assign sb_rsign = sb_p1[SB_LAT-1][2];
    assign sb_ovf   = sb_p1[SB_LAT-1][1];
    assign sb_dz    = sb_p1[SB_LAT-1][0];

endmodule
